// File: rtl/bridge_status_tracker.sv
// Passive monitor of the UART bridge status bundle: statistics, busy watchdog, error latches, state-event FIFO.
// One-cycle latency on every output; evt_ready pops the event FIFO, and pushes made while it is full are dropped and flagged.
module bridge_status_tracker #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             system_ready,
    input  logic             bridge_busy,
    input  logic [7:0]       bridge_error,
    input  logic [2:0]       parser_state,
    input  logic [2:0]       bridge_state,
    input  logic             internal_valid,
    input  logic             response_ready,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] error_count,
    output logic [7:0]       first_error,
    output logic [7:0]       last_error,
    output logic [CNT_W-1:0] busy_max,
    output logic             timeout_flag,
    output logic             evt_valid,
    output logic [5:0]       evt_data,
    input  logic             evt_ready,
    output logic             evt_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] r_txn, r_err_cnt, r_busy_max, r_busy_cnt;
    logic [7:0]       r_first, r_last, r_prev_err;
    logic [5:0]       r_prev_state, r_evt_data;
    logic             r_timeout, r_evt_valid, r_ovf;
    logic [AW:0]      r_wptr, r_rptr;
    logic [5:0]       r_mem [FIFO_DEPTH];

    logic             w_run, w_full, w_pop, w_push_req, w_push, w_drop, w_new_err;
    logic [5:0]       w_cur_state, w_head_nxt;
    logic [AW:0]      w_wptr_nxt, w_rptr_nxt;
    logic [CNT_W-1:0] w_busy_inc;

    always_comb begin
        w_run       = !rst && !clear;
        w_cur_state = {parser_state, bridge_state};
        w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_pop       = w_run && r_evt_valid && evt_ready;
        w_push_req  = w_run && system_ready && (w_cur_state != r_prev_state);
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        w_push      = w_push_req && (!w_full || w_pop);
        w_drop      = w_push_req && w_full && !w_pop;
        w_rptr_nxt  = r_rptr + {{AW{1'b0}}, w_pop};
        w_wptr_nxt  = r_wptr + {{AW{1'b0}}, w_push};
        w_head_nxt  = (w_push && (r_wptr == w_rptr_nxt)) ? w_cur_state
                                                          : r_mem[w_rptr_nxt[AW-1:0]];
        w_new_err   = system_ready && (bridge_error != 8'd0) && (bridge_error != r_prev_err);
        w_busy_inc  = sat_inc(r_busy_cnt);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_cur_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_txn        <= '0;
            r_err_cnt    <= '0;
            r_first      <= '0;
            r_last       <= '0;
            r_busy_max   <= '0;
            r_busy_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_evt_valid  <= 1'b0;
            r_evt_data   <= '0;
            r_ovf        <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_prev_state <= rst ? 6'd0 : w_cur_state;
            r_prev_err   <= rst ? 8'd0 : bridge_error;
        end else begin
            r_prev_state <= w_cur_state;
            r_prev_err   <= bridge_error;
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_evt_valid  <= (w_wptr_nxt != w_rptr_nxt);
            if (w_wptr_nxt != w_rptr_nxt) begin
                r_evt_data <= w_head_nxt;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (system_ready) begin
                if (internal_valid && response_ready) begin
                    r_txn <= sat_inc(r_txn);
                end
                if (w_new_err) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                    r_last    <= bridge_error;
                    // The count saturates rather than wraps, so zero means nothing captured yet.
                    if (r_err_cnt == '0) begin
                        r_first <= bridge_error;
                    end
                end
                if (bridge_busy) begin
                    r_busy_cnt <= w_busy_inc;
                    if (w_busy_inc > r_busy_max) begin
                        r_busy_max <= w_busy_inc;
                    end
                    if (r_busy_cnt == TO_LAST) begin
                        r_timeout <= 1'b1;
                    end
                end else begin
                    r_busy_cnt <= '0;
                end
            end else begin
                r_busy_cnt <= '0;
            end
        end
    end

    assign txn_count    = r_txn;
    assign error_count  = r_err_cnt;
    assign first_error  = r_first;
    assign last_error   = r_last;
    assign busy_max     = r_busy_max;
    assign timeout_flag = r_timeout;
    assign evt_valid    = r_evt_valid;
    assign evt_data     = r_evt_data;
    assign evt_overflow = r_ovf;
endmodule

// File: tb/tb_bridge_status_tracker.sv
// Bench for bridge_status_tracker: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_bridge_status_tracker;
    localparam int TO    = 1000;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1, clear = 1'b0, system_ready = 1'b0, bridge_busy = 1'b0;
    logic [7:0]    bridge_error = 8'd0;
    logic [2:0]    parser_state = 3'd0, bridge_state = 3'd0;
    logic          internal_valid = 1'b0, response_ready = 1'b0, evt_ready = 1'b0;
    logic [CW-1:0] txn_count, error_count, busy_max;
    logic [7:0]    first_error, last_error;
    logic          timeout_flag, evt_valid, evt_overflow;
    logic [5:0]    evt_data;

    bridge_status_tracker #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .system_ready(system_ready),
        .bridge_busy(bridge_busy), .bridge_error(bridge_error),
        .parser_state(parser_state), .bridge_state(bridge_state),
        .internal_valid(internal_valid), .response_ready(response_ready),
        .txn_count(txn_count), .error_count(error_count),
        .first_error(first_error), .last_error(last_error),
        .busy_max(busy_max), .timeout_flag(timeout_flag),
        .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_ready(evt_ready), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain counters, a run length and a queue of events.
    int         m_txn, m_err, m_busy_max, m_run;
    bit         m_seen, m_timeout, m_ovf;
    logic [7:0] m_first, m_last, m_prev_err;
    logic [5:0] m_prev, m_head;
    logic [5:0] q[$];

    task automatic model_zero();
        m_txn = 0; m_err = 0; m_busy_max = 0; m_run = 0;
        m_seen = 0; m_timeout = 0; m_ovf = 0;
        m_first = 0; m_last = 0; m_head = 0;
        q.delete();
    endtask

    task automatic tick();
        logic [5:0] st;
        int         sz;
        bit         pop;
        st = {parser_state, bridge_state};
        if (rst) begin
            model_zero();
            m_prev = 0; m_prev_err = 0;
        end else if (clear) begin
            model_zero();
            m_prev = st; m_prev_err = bridge_error;
        end else begin
            sz  = q.size();
            pop = (sz > 0) && evt_ready;
            if (system_ready) begin
                if (internal_valid && response_ready && m_txn < MAXC) m_txn++;
                if (bridge_error != 0 && bridge_error != m_prev_err) begin
                    if (m_err < MAXC) m_err++;
                    m_last = bridge_error;
                    if (!m_seen) m_first = bridge_error;
                    m_seen = 1;
                end
                if (bridge_busy) begin
                    if (m_run < MAXC) m_run++;
                    if (m_run > m_busy_max) m_busy_max = m_run;
                    if (m_run == TO) m_timeout = 1;
                end else m_run = 0;
            end else m_run = 0;
            if (pop) void'(q.pop_front());
            if (system_ready && st != m_prev) begin
                if (sz < DEPTH || pop) q.push_back(st);
                else m_ovf = 1;
            end
            m_prev = st; m_prev_err = bridge_error;
        end
        if (q.size() > 0) m_head = q[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        if (txn_count !== 0 || error_count !== 0 || busy_max !== 0) begin
            $display("FAIL reset_counters got txn=%0h err=%0h bmax=%0h exp 0", txn_count, error_count, busy_max);
        end else n_pass++;
        n_checks++;
        if (first_error !== 0 || last_error !== 0 || timeout_flag !== 0 || evt_overflow !== 0) begin
            $display("FAIL reset_flags got first=%0h last=%0h to=%b ovf=%b exp 0", first_error, last_error, timeout_flag, evt_overflow);
        end else n_pass++;
        n_checks++;
        if (evt_valid !== 0 || evt_data !== 0) begin
            $display("FAIL reset_evt got v=%b d=%0h exp 0", evt_valid, evt_data);
        end else n_pass++;
        n_checks++;
        rst = 1'b0;
    endtask

    task automatic test_first_event();
        system_ready = 1'b1; parser_state = 3'd1; bridge_state = 3'd2;
        tick();
        if (evt_valid !== 1'b1 || evt_data !== 6'b001_010) begin
            $display("FAIL first_event got v=%b d=%b exp v=1 d=001010", evt_valid, evt_data);
        end else n_pass++;
        n_checks++;
        tick(); tick();
        if (evt_valid !== 1'b1 || evt_data !== 6'b001_010) begin
            $display("FAIL first_event_hold got v=%b d=%b exp v=1 d=001010", evt_valid, evt_data);
        end else n_pass++;
        n_checks++;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick();
        if (evt_valid !== 1'b0 || evt_data !== 6'b001_010) begin
            $display("FAIL first_event_pop got v=%b d=%b exp v=0 d=001010", evt_valid, evt_data);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_watchdog();
        clear = 1'b1; tick(); clear = 1'b0;
        bridge_busy = 1'b1;
        for (int i = 0; i < TO - 1; i++) tick();
        bridge_busy = 1'b0; tick();
        if (timeout_flag !== 1'b0 || busy_max !== CW'(TO - 1)) begin
            $display("FAIL wdog_short got to=%b bmax=%0d exp to=0 bmax=%0d", timeout_flag, busy_max, TO - 1);
        end else n_pass++;
        n_checks++;
        bridge_busy = 1'b1;
        for (int i = 0; i < TO - 1; i++) tick();
        if (timeout_flag !== 1'b0) begin
            $display("FAIL wdog_early got to=%b exp 0", timeout_flag);
        end else n_pass++;
        n_checks++;
        tick();
        if (timeout_flag !== 1'b1 || busy_max !== CW'(TO)) begin
            $display("FAIL wdog_trip got to=%b bmax=%0d exp to=1 bmax=%0d", timeout_flag, busy_max, TO);
        end else n_pass++;
        n_checks++;
        bridge_busy = 1'b0; tick(); tick();
        if (timeout_flag !== 1'b1) begin
            $display("FAIL wdog_sticky got to=%b exp 1", timeout_flag);
        end else n_pass++;
        n_checks++;
        clear = 1'b1; tick(); clear = 1'b0;
        if (timeout_flag !== 1'b0 || busy_max !== 0) begin
            $display("FAIL wdog_clear got to=%b bmax=%0d exp 0", timeout_flag, busy_max);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_errors();
        logic [7:0] seq [6];
        seq = '{8'h00, 8'h12, 8'h12, 8'h00, 8'h12, 8'h34};
        bridge_error = 8'h00;
        clear = 1'b1; tick(); clear = 1'b0;
        foreach (seq[i]) begin
            bridge_error = seq[i];
            tick();
        end
        if (error_count !== 3 || first_error !== 8'h12 || last_error !== 8'h34) begin
            $display("FAIL errors got cnt=%0d first=%0h last=%0h exp 3/12/34", error_count, first_error, last_error);
        end else n_pass++;
        n_checks++;
        bridge_error = 8'h00; tick();
    endtask

    task automatic test_overflow();
        parser_state = 3'd0; bridge_state = 3'd0; evt_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            {parser_state, bridge_state} = 6'(i);
            tick();
        end
        if (evt_overflow !== 1'b0 || evt_data !== 6'd1) begin
            $display("FAIL ovf_fill got ovf=%b head=%0d exp ovf=0 head=1", evt_overflow, evt_data);
        end else n_pass++;
        n_checks++;
        {parser_state, bridge_state} = 6'(DEPTH + 1);
        tick();
        if (evt_overflow !== 1'b1 || evt_data !== 6'd1) begin
            $display("FAIL ovf_drop got ovf=%b head=%0d exp ovf=1 head=1", evt_overflow, evt_data);
        end else n_pass++;
        n_checks++;
        for (int i = 1; i <= DEPTH; i++) begin
            if (evt_valid !== 1'b1 || evt_data !== 6'(i)) begin
                $display("FAIL ovf_order got v=%b d=%0d exp v=1 d=%0d", evt_valid, evt_data, i);
            end else n_pass++;
            n_checks++;
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        end
        if (evt_valid !== 1'b0) begin
            $display("FAIL ovf_empty got v=%b exp 0", evt_valid);
        end else n_pass++;
        n_checks++;

        {parser_state, bridge_state} = 6'd0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            {parser_state, bridge_state} = 6'(i);
            tick();
        end
        {parser_state, bridge_state} = 6'(DEPTH + 1);
        evt_ready = 1'b1;
        tick();
        if (evt_overflow !== 1'b0 || evt_data !== 6'd2) begin
            $display("FAIL full_push_pop got ovf=%b head=%0d exp ovf=0 head=2", evt_overflow, evt_data);
        end else n_pass++;
        n_checks++;
        for (int i = 2; i <= DEPTH + 1; i++) begin
            if (evt_valid !== 1'b1 || evt_data !== 6'(i)) begin
                $display("FAIL full_order got v=%b d=%0d exp v=1 d=%0d", evt_valid, evt_data, i);
            end else n_pass++;
            n_checks++;
            tick();
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_gating();
        bridge_error = 8'h00; {parser_state, bridge_state} = 6'o33;
        clear = 1'b1; tick(); clear = 1'b0;
        internal_valid = 1'b1; response_ready = 1'b1;
        repeat (3) tick();
        internal_valid = 1'b0;
        bridge_busy = 1'b1; repeat (5) tick(); bridge_busy = 1'b0;
        bridge_error = 8'h55; tick(); bridge_error = 8'h00; tick();
        system_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bridge_busy = 1'b1;
            internal_valid = 1'($urandom); response_ready = 1'b1;
            bridge_error = 8'($urandom_range(1, 255));
            {parser_state, bridge_state} = 6'($urandom);
            tick();
        end
        bridge_busy = 1'b0; internal_valid = 1'b0; response_ready = 1'b0;
        bridge_error = 8'h55; {parser_state, bridge_state} = 6'o21;
        tick();
        if (txn_count !== 3 || error_count !== 1 || busy_max !== 5 || last_error !== 8'h55) begin
            $display("FAIL gate_hold got txn=%0d err=%0d bmax=%0d last=%0h exp 3/1/5/55", txn_count, error_count, busy_max, last_error);
        end else n_pass++;
        n_checks++;
        if (evt_valid !== 1'b0 || timeout_flag !== 1'b0) begin
            $display("FAIL gate_fifo got v=%b to=%b exp 0/0", evt_valid, timeout_flag);
        end else n_pass++;
        n_checks++;
        system_ready = 1'b1;
        tick();
        if (evt_valid !== 1'b0 || error_count !== 1) begin
            $display("FAIL gate_reenable got v=%b err=%0d exp v=0 err=1", evt_valid, error_count);
        end else n_pass++;
        n_checks++;
        {parser_state, bridge_state} = 6'o22;
        tick();
        if (evt_valid !== 1'b1 || evt_data !== 6'o22) begin
            $display("FAIL gate_change got v=%b d=%o exp v=1 d=22", evt_valid, evt_data);
        end else n_pass++;
        n_checks++;
        bridge_error = 8'h00;
    endtask

    task automatic test_clear_collision();
        internal_valid = 1'b1; response_ready = 1'b1; bridge_error = 8'h77;
        clear = 1'b1; tick(); clear = 1'b0;
        if (txn_count !== 0 || error_count !== 0 || first_error !== 0 || evt_valid !== 0 || evt_overflow !== 0) begin
            $display("FAIL clear_collide got txn=%0d err=%0d first=%0h v=%b ovf=%b exp 0", txn_count, error_count, first_error, evt_valid, evt_overflow);
        end else n_pass++;
        n_checks++;
        internal_valid = 1'b0;
        tick();
        if (error_count !== 0 || txn_count !== 0) begin
            $display("FAIL clear_prev_err got err=%0d txn=%0d exp 0/0", error_count, txn_count);
        end else n_pass++;
        n_checks++;
        internal_valid = 1'b1; tick(); internal_valid = 1'b0;
        if (txn_count !== 1) begin
            $display("FAIL clear_resume got txn=%0d exp 1", txn_count);
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 999) == 0);
            clear        = ($urandom_range(0, 199) == 0);
            system_ready = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bridge_busy = ~bridge_busy;
            if ($urandom_range(0, 3) == 0) bridge_error = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) {parser_state, bridge_state} = 6'($urandom);
            internal_valid = 1'($urandom);
            response_ready = 1'($urandom);
            evt_ready      = ($urandom_range(0, 3) == 0);
            tick();
            if (txn_count !== CW'(m_txn) || error_count !== CW'(m_err) || busy_max !== CW'(m_busy_max)) begin
                $display("FAIL rand_counts cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, txn_count, error_count, busy_max, m_txn, m_err, m_busy_max);
            end else n_pass++;
            n_checks++;
            if (first_error !== m_first || last_error !== m_last) begin
                $display("FAIL rand_errcodes cyc=%0d got %0h/%0h exp %0h/%0h", c, first_error, last_error, m_first, m_last);
            end else n_pass++;
            n_checks++;
            if (timeout_flag !== m_timeout || evt_overflow !== m_ovf) begin
                $display("FAIL rand_flags cyc=%0d got to=%b ovf=%b exp to=%b ovf=%b", c, timeout_flag, evt_overflow, m_timeout, m_ovf);
            end else n_pass++;
            n_checks++;
            if (evt_valid !== (q.size() > 0) || evt_data !== m_head) begin
                $display("FAIL rand_evt cyc=%0d got v=%b d=%o exp v=%b d=%o", c, evt_valid, evt_data, q.size() > 0, m_head);
            end else n_pass++;
            n_checks++;
        end
        rst = 1'b0; clear = 1'b0;
    endtask

    initial begin
        m_prev = 0; m_prev_err = 0;
        model_zero();
        #1;
        test_reset();
        test_first_event();
        test_watchdog();
        test_errors();
        test_overflow();
        test_gating();
        test_clear_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bridge_status_tracker.md
Name: bridge_status_tracker

Overview:
Downstream consumer of the bridge status bundle (busy, error code, ready, parser/bridge FSM states, valid/ready handshake). It accumulates run-time statistics, runs a busy-timeout watchdog, latches error codes, and buffers FSM state-change events in a small FIFO. A register block or debug UART reader drains that FIFO. It sits beside the UART bridge and is purely observational: it never drives the bridge.

Parameters:
TIMEOUT_CYCLES, 1000, consecutive bridge_busy cycles that trip the watchdog (2..2^CNT_W-1)
FIFO_DEPTH, 8, state-event FIFO entries; power of two, >=2
CNT_W, 16, width of all statistic counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clear  input  1  synchronous clear of stats, sticky flags and FIFO
system_ready  input  1  monitoring enable; capture gated by this
bridge_busy  input  1  bridge transaction in progress
bridge_error  input  8  bridge error code, 0 = no error
parser_state  input  3  parser FSM state
bridge_state  input  3  bridge FSM state
internal_valid  input  1  parser-to-bridge command valid
response_ready  input  1  bridge response accepted
txn_count  output  CNT_W  completed handshakes (internal_valid & response_ready)
error_count  output  CNT_W  new-error events
first_error  output  8  first nonzero error code since reset/clear
last_error  output  8  most recent new error code
busy_max  output  CNT_W  longest busy run in cycles
timeout_flag  output  1  sticky watchdog trip
evt_valid  output  1  FIFO non-empty
evt_data  output  6  {parser_state, bridge_state} at change
evt_ready  input  1  pop strobe; pop when evt_valid & evt_ready
evt_overflow  output  1  sticky: event dropped because FIFO was full

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, prev_state=0, prev_error=0, busy_cnt=0, FIFO empty. clear=1 has the same effect, except that prev_state and prev_error load the current inputs. This prevents a spurious event on the next cycle.
- Priority: rst > clear > normal. During a clear cycle, no capture, push or pop occurs.
- Gating: with system_ready=0, counters, flags and FIFO contents hold. busy_cnt resets to 0. No pushes. Pops still allowed. prev_state and prev_error track the inputs.
- All arithmetic saturates at 2^CNT_W-1; no wrap-around.
- txn_count increments by 1 on every edge with internal_valid & response_ready.
- Error capture: new error when bridge_error!=0 and bridge_error!=prev_error. On a new error:
  - error_count increments.
  - last_error updates.
  - first_error loads only if no error has been captured since reset/clear.
  - prev_error updates every enabled cycle.
  - A constant nonzero code counts once. Error→0→same error counts twice.
- Watchdog:
  - busy_cnt increments (saturating) each cycle bridge_busy=1. It returns to 0 on the cycle bridge_busy=0.
  - busy_max <= max(busy_max, busy_cnt+1) each busy cycle, updated the same edge.
  - timeout_flag sets on the edge where bridge_busy=1 and busy_cnt==TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th consecutive busy cycle. It is sticky until rst/clear.
- Event FIFO:
  - Push on an edge where {parser_state,bridge_state}!=prev_state; prev_state updates on the same edge.
  - evt_valid and evt_data are registered. An event sampled at edge k is visible after edge k (1-cycle latency).
  - evt_data always shows the head entry. When evt_valid=0, evt_data holds its last value (X not allowed).
  - Pop on evt_valid & evt_ready. The next entry appears after that edge.
  - Full and push without pop: entry dropped, evt_overflow sets (sticky).
  - Full with push and pop on the same edge: both occur, no overflow, occupancy unchanged.
  - Empty with push: pop ignored because evt_valid=0. The entry appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit so full and empty are distinguishable.
- First enabled cycle after reset: if the inputs are a nonzero state pair, one event is pushed, since prev_state=0.

Test Plan:
- Reset, system_ready=1, parser_state=1, bridge_state=2 held → evt_valid=1 one cycle later, evt_data=6'b001_010; holding state pushes nothing further; pop → evt_valid=0.
- bridge_busy high 999 cycles then low → timeout_flag=0, busy_max=999. Next busy run of 1000 cycles → timeout_flag=1 on the 1000th edge, busy_max=1000; flag persists after busy drops until clear.
- bridge_error sequence 0,0x12,0x12,0,0x12,0x34 → error_count=3, first_error=0x12, last_error=0x34.
- 9 distinct state changes, evt_ready=0, FIFO_DEPTH=8 → 8 entries retained in order, evt_overflow=1. Then push and pop on the same edge while full → no new overflow, order preserved.
- system_ready=0 with busy, handshakes and state changes → all stats/FIFO unchanged. Re-enable → no event unless the state changes afterwards.
- clear asserted the same cycle as a handshake and a new error → all stats 0, FIFO empty, flags 0; the handshake and error are not counted.
